// File: rtl/iir_pkg.sv
// Shared types and helpers for the IIR filter datapath.
//
// Contents:
//   SAMPLE_W, SAMPLE_MAX, SAMPLE_MIN : 16-bit signed sample range
//   WIDE_W                           : width of intermediate values passed to sat16
//   sample_t                         : signed 16-bit sample
//   res_t                            : registered result stage (valid + data)
//   sat16()                          : clip a wide signed value to sample_t, report clipping
package iir_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int          SAMPLE_MAX = 32767;
  localparam int          SAMPLE_MIN = -32768;

  // Wide enough for the largest accumulator (16 + 6 bits) plus rounding headroom.
  localparam int unsigned WIDE_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic    valid;
    sample_t data;
  } res_t;

  function automatic sample_t sat16(input logic signed [WIDE_W-1:0] value,
                                    output logic clipped);
    sample_t res;
    clipped = 1'b0;
    res     = sample_t'(value);
    if (value > SAMPLE_MAX) begin
      res     = sample_t'(SAMPLE_MAX);
      clipped = 1'b1;
    end else if (value < SAMPLE_MIN) begin
      res     = sample_t'(SAMPLE_MIN);
      clipped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/iir_decim_fifo2.sv
// Two-entry valid/ready output buffer for the decimator.
//
// The head entry is a register driven straight to the consumer, so there is no
// combinational path from pop_ready to head_valid/head_data. A push while full is
// ignored unless a pop happens in the same cycle, in which case it is accepted.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push        : new result available this cycle
//   push_data   : result to store
//   pop_ready   : consumer accepts head this cycle
//   head_data   : oldest stored result (held stable until popped)
//   head_valid  : buffer is non-empty
//   full        : both entries occupied
module iir_decim_fifo2
  import iir_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  sample_t push_data,
  input  logic    pop_ready,
  output sample_t head_data,
  output logic    head_valid,
  output logic    full
);

  logic [1:0] count_q, count_d;
  sample_t    head_q, head_d;
  sample_t    tail_q, tail_d;
  logic       pop;
  logic       push_ok;

  always_comb begin
    pop     = pop_ready & (count_q != 2'd0);
    push_ok = push & ((count_q != 2'd2) | pop);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_ok, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = push_data;
          count_d = 2'd1;
        end else begin
          tail_d  = push_data;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the entry behind the head moves up.
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = (count_q != 2'd0);
  assign full       = (count_q == 2'd2);

endmodule

// File: rtl/iir_decim.sv
// Integrate-and-dump decimator placed after the second-order IIR cascade.
//
// Sums DECIM enabled input samples, scales the sum by 2^-SHIFT with round-half-up,
// clips to 16 bits and hands the result to a 2-entry valid/ready buffer. Latency
// from the last contributing input edge to y_valid is 2 clocks with an empty buffer.
//
// Optional feature macro: IIR_DECIM_PEAK_EN adds peak_abs, the running maximum of
// |result| over results written into the buffer.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   x_en, x_in : input strobe and signed sample
//   y_data     : signed decimated result, valid when y_valid
//   y_valid    : buffer head holds data
//   y_ready    : consumer accepts head
//   sat_flag   : sticky, a result was clipped
//   ovr_flag   : sticky, a result was dropped because the buffer was full
//   clr_flags  : clears the sticky flags (a same-cycle set event wins)
//   peak_abs   : (IIR_DECIM_PEAK_EN only) running peak magnitude
module iir_decim
  import iir_pkg::*;
#(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned LOG2_DECIM = 2,
  parameter int unsigned SHIFT      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_en,
  input  logic signed [15:0] x_in,
  output logic signed [15:0] y_data,
  output logic               y_valid,
  input  logic               y_ready,
  output logic               sat_flag,
  output logic               ovr_flag,
  input  logic               clr_flags
`ifdef IIR_DECIM_PEAK_EN
  ,
  output logic        [15:0] peak_abs
`endif
);

  localparam int unsigned AccW      = SAMPLE_W + LOG2_DECIM;
  localparam int          RoundBias = (2 ** SHIFT) / 2;

  logic signed [AccW-1:0]       acc_q, acc_d;
  logic        [LOG2_DECIM-1:0] phase_q, phase_d;
  logic signed [AccW-1:0]       sum;
  logic                         dump;
  logic signed [WIDE_W-1:0]     sum_wide;
  logic signed [WIDE_W-1:0]     rounded;
  logic signed [WIDE_W-1:0]     scaled;
  sample_t                      res_data;
  logic                         clip;
  res_t                         res_q;
  logic                         sat_q, sat_d;
  logic                         ovr_q, ovr_d;
  logic                         fifo_full;
  logic                         pop;
  logic                         drop;

  // Accumulate / dump. The accumulator is wide enough for DECIM full-scale samples.
  always_comb begin
    sum     = acc_q + AccW'(x_in);
    dump    = x_en & (phase_q == LOG2_DECIM'(DECIM - 1));
    acc_d   = acc_q;
    phase_d = phase_q;
    if (x_en) begin
      if (dump) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + LOG2_DECIM'(1);
      end
    end
  end

  // Scale with round-half-up; RoundBias is zero when SHIFT is zero.
  always_comb begin
    sum_wide = WIDE_W'(sum);
    rounded  = sum_wide + RoundBias;
    scaled   = rounded >>> SHIFT;
    clip     = 1'b0;
    res_data = sat16(scaled, clip);
  end

  assign pop  = y_valid & y_ready;
  assign drop = res_q.valid & fifo_full & ~pop;

  // Set events take priority over a simultaneous clear.
  always_comb begin
    sat_d = (dump & clip) | (sat_q & ~clr_flags);
    ovr_d = drop | (ovr_q & ~clr_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      phase_q <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      res_q.valid <= dump;
      res_q.data  <= res_data;
      sat_q       <= sat_d;
      ovr_q       <= ovr_d;
    end
  end

  iir_decim_fifo2 u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (res_q.valid),
    .push_data  (res_q.data),
    .pop_ready  (y_ready),
    .head_data  (y_data),
    .head_valid (y_valid),
    .full       (fifo_full)
  );

  assign sat_flag = sat_q;
  assign ovr_flag = ovr_q;

`ifdef IIR_DECIM_PEAK_EN
  logic        wr_v_q;
  logic [15:0] wr_abs_q, wr_abs_d;
  logic [15:0] peak_q, peak_d;

  always_comb begin
    // |-32768| does not fit, so it reports as full-scale positive.
    if (res_q.data == sample_t'(SAMPLE_MIN)) begin
      wr_abs_d = 16'(SAMPLE_MAX);
    end else if (res_q.data < 0) begin
      wr_abs_d = -res_q.data;
    end else begin
      wr_abs_d = res_q.data;
    end
    peak_d = clr_flags ? '0 : peak_q;
    if (wr_v_q && (wr_abs_q > peak_d)) begin
      peak_d = wr_abs_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_v_q   <= 1'b0;
      wr_abs_q <= '0;
      peak_q   <= '0;
    end else begin
      wr_v_q   <= res_q.valid & ~drop;
      wr_abs_q <= wr_abs_d;
      peak_q   <= peak_d;
    end
  end

  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_iir_decim.sv
// Self-checking bench for iir_decim. Two instances share the stimulus: one with
// SHIFT=2 (unity gain) and one with SHIFT=0 (gain 4, used to reach clipping).
// A frame-level model keeps raw frame sums and a result queue; outputs are
// compared every cycle, plus hand-computed literals at key points.
module tb_iir_decim;

  localparam int SH[2] = '{2, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, x_en, y_ready, clr_flags;
  logic signed [15:0] x_in;
  logic signed [15:0] y_data_a, y_data_b;
  logic               y_valid_a, y_valid_b, sat_a, sat_b, ovr_a, ovr_b;
`ifdef IIR_DECIM_PEAK_EN
  logic [15:0] peak_a, peak_b;
`endif

  iir_decim #(.DECIM(4), .LOG2_DECIM(2), .SHIFT(2)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .x_en      (x_en),
    .x_in      (x_in),
    .y_data    (y_data_a),
    .y_valid   (y_valid_a),
    .y_ready   (y_ready),
    .sat_flag  (sat_a),
    .ovr_flag  (ovr_a),
    .clr_flags (clr_flags)
`ifdef IIR_DECIM_PEAK_EN
    ,
    .peak_abs  (peak_a)
`endif
  );

  iir_decim #(.DECIM(4), .LOG2_DECIM(2), .SHIFT(0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .x_en      (x_en),
    .x_in      (x_in),
    .y_data    (y_data_b),
    .y_valid   (y_valid_b),
    .y_ready   (y_ready),
    .sat_flag  (sat_b),
    .ovr_flag  (ovr_b),
    .clr_flags (clr_flags)
`ifdef IIR_DECIM_PEAK_EN
    ,
    .peak_abs  (peak_b)
`endif
  );

  // Model state
  int acc_m, cnt_m;
  int q[$];
  bit pend_v;
  int pend_sum;
  bit sat_m[2];
  bit ovr_m;
  bit fresh;
  int n_chk, n_pass;

  function automatic int scale_raw(input int s, input int sh);
    int d;
    int t;
    d = 1 << sh;
    t = s + d / 2;
    if (t >= 0) return t / d;
    return -((-t + d - 1) / d);
  endfunction

  function automatic int scale(input int s, input int sh);
    int r;
    r = scale_raw(s, sh);
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  function automatic bit clips(input int s, input int sh);
    int r;
    r = scale_raw(s, sh);
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit en, input int x, input bit rdy, input bit clr,
                            input bit rst);
    bit sat_set[2];
    bit ovr_set;
    if (rst) begin
      acc_m  = 0;
      cnt_m  = 0;
      q.delete();
      pend_v = 0;
      sat_m  = '{0, 0};
      ovr_m  = 0;
      fresh  = 1;
      return;
    end
    sat_set = '{0, 0};
    ovr_set = 0;
    if (rdy && q.size() > 0) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < 2) begin
        q.push_back(pend_sum);
        fresh = 0;
      end else begin
        ovr_set = 1;
      end
    end
    pend_v = 0;
    if (en) begin
      if (cnt_m == 3) begin
        pend_sum = acc_m + x;
        pend_v   = 1;
        acc_m    = 0;
        cnt_m    = 0;
        for (int i = 0; i < 2; i++) sat_set[i] = clips(pend_sum, SH[i]);
      end else begin
        acc_m += x;
        cnt_m++;
      end
    end
    for (int i = 0; i < 2; i++) sat_m[i] = sat_set[i] | (sat_m[i] & !clr);
    ovr_m = ovr_set | (ovr_m & !clr);
  endtask

  task automatic cmp(input int i, input logic v, input logic signed [15:0] d,
                     input logic s, input logic o);
    chk($sformatf("y_valid[%0d]", i), int'(v), int'(q.size() > 0));
    if (q.size() > 0) chk($sformatf("y_data[%0d]", i), int'(d), scale(q[0], SH[i]));
    else if (fresh) chk($sformatf("y_data_reset[%0d]", i), int'(d), 0);
    chk($sformatf("sat_flag[%0d]", i), int'(s), int'(sat_m[i]));
    chk($sformatf("ovr_flag[%0d]", i), int'(o), int'(ovr_m));
  endtask

  // One clock: drive, model the edge, compare at the falling edge.
  task automatic cyc(input bit en, input int x, input bit rdy, input bit clr, input bit rst);
    x_en      = en;
    x_in      = 16'(x);
    y_ready   = rdy;
    clr_flags = clr;
    reset     = rst;
    @(posedge clk);
    model_step(en, x, rdy, clr, rst);
    @(negedge clk);
    cmp(0, y_valid_a, y_data_a, sat_a, ovr_a);
    cmp(1, y_valid_b, y_data_b, sat_b, ovr_b);
  endtask

  task automatic frame(input int x, input bit rdy);
    for (int k = 0; k < 4; k++) cyc(1, x, rdy, 0, 0);
  endtask

  initial begin
    int seq_p[4];
    int seq_n[4];
    seq_p = '{1, 2, 2, 2};
    seq_n = '{-1, -2, -2, -2};
    n_chk = 0;
    n_pass = 0;
    reset = 1; x_en = 0; x_in = 0; y_ready = 1; clr_flags = 0;
    acc_m = 0; cnt_m = 0; pend_v = 0; sat_m = '{0, 0}; ovr_m = 0; fresh = 1;
    @(negedge clk);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("lit_rst_valid", int'(y_valid_a), 0);
    chk("lit_rst_data", int'(y_data_a), 0);
    chk("lit_rst_sat", int'(sat_b), 0);

    // Constant 1000, always ready: first result 2 clocks after the 4th input.
    for (int k = 0; k < 12; k++) begin
      cyc(1, 1000, 1, 0, 0);
      if (k == 3) chk("lit_lat_not_yet", int'(y_valid_a), 0);
      if (k == 4) begin
        chk("lit_lat_valid", int'(y_valid_a), 1);
        chk("lit_1000_a", int'(y_data_a), 1000);
        chk("lit_1000_b", int'(y_data_b), 4000);
      end
      if (k == 5) chk("lit_popped", int'(y_valid_a), 0);
    end
    repeat (3) cyc(0, 0, 1, 0, 0);
    chk("lit_flags_quiet", int'(sat_a | ovr_a), 0);

    // Rounding, positive and negative.
    for (int k = 0; k < 4; k++) cyc(1, seq_p[k], 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("lit_round_pos_a", int'(y_data_a), 2);
    chk("lit_round_pos_b", int'(y_data_b), 7);
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, seq_n[k], 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("lit_round_neg_a", int'(y_data_a), -2);
    chk("lit_round_neg_b", int'(y_data_b), -7);
    cyc(0, 0, 1, 0, 0);

    // Saturation, clear, and set-wins-over-clear.
    frame(20000, 1);
    cyc(0, 0, 1, 0, 0);
    chk("lit_sat_data_b", int'(y_data_b), 32767);
    chk("lit_sat_data_a", int'(y_data_a), 20000);
    chk("lit_sat_flag_b", int'(sat_b), 1);
    chk("lit_sat_flag_a", int'(sat_a), 0);
    cyc(0, 0, 1, 1, 0);
    chk("lit_sat_cleared", int'(sat_b), 0);
    for (int k = 0; k < 3; k++) cyc(1, 20000, 1, 0, 0);
    cyc(1, 20000, 1, 1, 0);
    chk("lit_set_wins", int'(sat_b), 1);
    cyc(0, 0, 1, 0, 0);
    frame(-20000, 1);
    cyc(0, 0, 1, 0, 0);
    chk("lit_sat_neg_b", int'(y_data_b), -32768);
    chk("lit_sat_neg_a", int'(y_data_a), -20000);
    cyc(0, 0, 1, 1, 0);

    // Backpressure for three frames: two held, third dropped.
    for (int f = 1; f <= 3; f++) frame(f * 100, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_hold_head", int'(y_data_a), 100);
    chk("lit_ovr", int'(ovr_a), 1);
    cyc(0, 0, 1, 0, 0);
    chk("lit_drain_second", int'(y_data_a), 200);
    cyc(0, 0, 1, 0, 0);
    chk("lit_drain_empty", int'(y_valid_a), 0);
    cyc(0, 0, 1, 1, 0);

    // x_en toggling every clock.
    for (int k = 0; k < 16; k++) begin
      cyc(k % 2 == 0, -500, 1, 0, 0);
      if (k == 15) chk("lit_toggle_a", int'(y_data_a), -500);
    end
    repeat (2) cyc(0, 0, 1, 0, 0);

    // Reset mid-frame discards the partial sum and the sticky flags.
    frame(20000, 1);
    cyc(1, 77, 1, 0, 0);
    cyc(1, 77, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    chk("lit_mid_rst_valid", int'(y_valid_a), 0);
    chk("lit_mid_rst_data", int'(y_data_b), 0);
    chk("lit_mid_rst_sat", int'(sat_b), 0);
    frame(300, 1);
    cyc(0, 0, 1, 0, 0);
    chk("lit_after_rst_a", int'(y_data_a), 300);
    chk("lit_after_rst_b", int'(y_data_b), 1200);
    cyc(0, 0, 1, 0, 0);

    // Mixed traffic: sparse enables, intermittent ready, occasional clears.
    for (int k = 0; k < 300; k++) begin
      cyc(($urandom % 4) != 0, int'($urandom_range(0, 65535)) - 32768,
          ($urandom % 3) == 0, ($urandom % 16) == 0, 0);
    end
    repeat (4) cyc(0, 0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
